gol_generation_scheduler: RTL and testbench

- Sequences one Game of Life generation update per enabled tick.
- The tick comes from the 1.5 Hz clock-enable generator. The block divides it by a user speed setting and handles run/pause/single-step/seed-load control.
- Drives the row-compute engine through a per-row req/done handshake, then issues a one-cycle commit to swap the cell buffers.
- Sits between the clock-enable generator, the user-input debouncers and the cell-array datapath.

---
 rtl/gol_pkg.sv | 16 +
 rtl/gol_tick_divider.sv | 39 +++
 rtl/gol_generation_scheduler.sv | 150 +++++++++++++++
 tb/tb_gol_generation_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared types and constants for the Game of Life generation sequencing.
package gol_pkg;

  localparam int unsigned ROWS    = 16;
  localparam int unsigned ROW_W   = $clog2(ROWS);
  localparam int unsigned GEN_W   = 16;
  localparam int unsigned SPEED_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ROW    = 2'd2,
    COMMIT = 2'd3
  } gol_sched_state_t;

endpackage

// File: rtl/gol_tick_divider.sv
// Divides the incoming tick by (speed+1) while running; run_trig_c is
// combinational so a trigger is seen in the same cycle as its tick.
module gol_tick_divider #(
  parameter int unsigned SPEED_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_i,
  input  logic               run_i,
  input  logic [SPEED_W-1:0] speed_i,
  output logic               run_trig_c
);

  logic [SPEED_W-1:0] div_cnt_q;
  logic [SPEED_W-1:0] div_cnt_d;
  logic               match_c;

  // Compare against the live speed so a change applies at the next compare
  always_comb begin
    match_c    = (div_cnt_q == speed_i);
    run_trig_c = run_i && tick_i && match_c;
    div_cnt_d  = div_cnt_q;
    if (!run_i) begin
      div_cnt_d = '0;
    end else if (tick_i) begin
      div_cnt_d = match_c ? '0 : div_cnt_q + SPEED_W'(1);
    end
  end

  // Divider count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/gol_generation_scheduler.sv
// Sequences one generation per trigger: walks rows via req/done, then
// commits the buffer swap; also handles seed load and overrun tracking.
module gol_generation_scheduler #(
  parameter int unsigned ROWS    = gol_pkg::ROWS,
  parameter int unsigned ROW_W   = $clog2(ROWS),
  parameter int unsigned GEN_W   = gol_pkg::GEN_W,
  parameter int unsigned SPEED_W = gol_pkg::SPEED_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               run,
  input  logic               step,
  input  logic               load,
  input  logic [SPEED_W-1:0] speed,
  input  logic               row_done,
  output logic               row_req,
  output logic [ROW_W-1:0]   row_idx,
  output logic               commit,
  output logic               load_en,
  output logic               busy,
  output logic               overrun,
  output logic [GEN_W-1:0]   gen_count
);

  import gol_pkg::*;

  gol_sched_state_t   state_q;
  gol_sched_state_t   state_d;
  logic [ROW_W-1:0]   row_idx_q;
  logic [ROW_W-1:0]   row_idx_d;
  logic [GEN_W-1:0]   gen_q;
  logic [GEN_W-1:0]   gen_d;
  logic               overrun_q;
  logic               overrun_d;
  logic               load_pending_q;
  logic               load_pending_d;

  logic               run_trig_c;
  logic               trig_c;
  logic               row_last_c;
  logic               accept_c;

  gol_tick_divider #(
    .SPEED_W (SPEED_W)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .tick_i     (tick),
    .run_i      (run),
    .speed_i    (speed),
    .run_trig_c (run_trig_c)
  );

  // Trigger sources and row acceptance; step only counts while paused
  always_comb begin
    trig_c     = run_trig_c || (!run && step);
    row_last_c = (row_idx_q == ROW_W'(ROWS - 1));
    accept_c   = (state_q == ROW) && row_done;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a pending or fresh load beats a trigger in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load || load_pending_q) begin
          state_d = LOAD;
        end else if (trig_c) begin
          state_d = ROW;
        end
      end
      LOAD:    state_d = IDLE;
      ROW: begin
        if (accept_c && row_last_c) begin
          state_d = COMMIT;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state register or driven from registers
  always_comb begin
    row_req   = (state_q == ROW);
    commit    = (state_q == COMMIT);
    load_en   = (state_q == LOAD);
    busy      = (state_q != IDLE);
    row_idx   = row_idx_q;
    overrun   = overrun_q;
    gen_count = gen_q;
  end

  // Next values for row index, generation count and sticky flags
  always_comb begin
    row_idx_d      = row_idx_q;
    gen_d          = gen_q;
    overrun_d      = overrun_q;
    load_pending_d = load_pending_q;

    if (accept_c && !row_last_c) begin
      row_idx_d = row_idx_q + ROW_W'(1);
    end

    if (state_q == COMMIT) begin
      row_idx_d = '0;
      gen_d     = gen_q + GEN_W'(1);
    end

    // LOAD clears flags and count; anything arriving then is superseded
    if (state_q == LOAD) begin
      gen_d          = '0;
      overrun_d      = 1'b0;
      load_pending_d = 1'b0;
    end else if (state_q != IDLE) begin
      if (run_trig_c) begin
        overrun_d = 1'b1;
      end
      if (load) begin
        load_pending_d = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_idx_q      <= '0;
      gen_q          <= '0;
      overrun_q      <= 1'b0;
      load_pending_q <= 1'b0;
    end else begin
      row_idx_q      <= row_idx_d;
      gen_q          <= gen_d;
      overrun_q      <= overrun_d;
      load_pending_q <= load_pending_d;
    end
  end

endmodule

// File: tb/tb_gol_generation_scheduler.sv
// Directed bench for gol_generation_scheduler.
module tb_gol_generation_scheduler;

  logic        clk;
  logic        reset;
  logic        tick;
  logic        run;
  logic        step;
  logic        load;
  logic [1:0]  speed;
  logic        row_done;
  logic        row_req;
  logic [3:0]  row_idx;
  logic        commit;
  logic        load_en;
  logic        busy;
  logic        overrun;
  logic [15:0] gen_count;

  logic        done_lvl;
  logic        stall_en;
  logic [3:0]  stall_row;

  int n_pass  = 0;
  int n_total = 0;
  int commit_cnt = 0;
  int c0;

  gol_generation_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .run       (run),
    .step      (step),
    .load      (load),
    .speed     (speed),
    .row_done  (row_done),
    .row_req   (row_req),
    .row_idx   (row_idx),
    .commit    (commit),
    .load_en   (load_en),
    .busy      (busy),
    .overrun   (overrun),
    .gen_count (gen_count)
  );

  // Engine model: accepts every row except a chosen stalled one
  assign row_done = done_lvl && !(stall_en && row_idx == stall_row);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (commit === 1'b1) commit_cnt++;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick = 0; run = 0; step = 0; load = 0; speed = 2'd0;
    done_lvl = 1'b1; stall_en = 1'b0; stall_row = 4'd0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic pulse_tick();
    tick = 1'b1; cyc(); tick = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({row_req, commit, load_en, busy, overrun} !== 5'b0 || row_idx !== 4'd0 || gen_count !== 16'd0)
      $display("FAIL reset_outputs got req=%0b com=%0b ld=%0b busy=%0b ovr=%0b idx=%0d gen=%0d exp all 0",
               row_req, commit, load_en, busy, overrun, row_idx, gen_count);
    else n_pass++;
  endtask

  task automatic test_latency();
    do_reset();
    run = 1'b1;
    cyc(); cyc();
    pulse_tick();
    for (int k = 0; k < 16; k++) begin
      n_total++;
      if (row_req !== 1'b1 || row_idx !== 4'(k))
        $display("FAIL lat_row%0d got req=%0b idx=%0d exp req=1 idx=%0d", k, row_req, row_idx, k);
      else n_pass++;
      cyc();
    end
    n_total++;
    if (commit !== 1'b1 || row_req !== 1'b0)
      $display("FAIL lat_commit got commit=%0b req=%0b exp 1 0", commit, row_req);
    else n_pass++;
    cyc();
    n_total++;
    if (busy !== 1'b0 || commit !== 1'b0 || gen_count !== 16'd1)
      $display("FAIL lat_idle got busy=%0b commit=%0b gen=%0d exp 0 0 1", busy, commit, gen_count);
    else n_pass++;
  endtask

  task automatic test_speed();
    do_reset();
    run = 1'b1; speed = 2'd2;
    c0 = commit_cnt;
    for (int t = 1; t <= 6; t++) begin
      pulse_tick();
      repeat (1016) cyc();
      if (t == 2) begin
        n_total++;
        if (commit_cnt - c0 !== 0) $display("FAIL speed_after2 got=%0d exp=0", commit_cnt - c0);
        else n_pass++;
      end
      if (t == 3) begin
        n_total++;
        if (commit_cnt - c0 !== 1) $display("FAIL speed_after3 got=%0d exp=1", commit_cnt - c0);
        else n_pass++;
      end
    end
    n_total++;
    if (commit_cnt - c0 !== 2 || gen_count !== 16'd2)
      $display("FAIL speed_total got commits=%0d gen=%0d exp 2 2", commit_cnt - c0, gen_count);
    else n_pass++;
  endtask

  task automatic test_step();
    do_reset();
    stall_row = 4'd4; stall_en = 1'b1;
    c0 = commit_cnt;
    for (int t = 0; t < 3; t++) begin
      pulse_tick();
      n_total++;
      if (busy !== 1'b0) $display("FAIL step_tick_paused%0d got busy=%0b exp 0", t, busy);
      else n_pass++;
    end
    step = 1'b1; cyc(); step = 1'b0;
    n_total++;
    if (row_req !== 1'b1 || row_idx !== 4'd0)
      $display("FAIL step_start got req=%0b idx=%0d exp 1 0", row_req, row_idx);
    else n_pass++;
    for (int i = 0; i < 20 && row_idx !== 4'd4; i++) cyc();
    step = 1'b1; cyc(); step = 1'b0;
    n_total++;
    if (overrun !== 1'b0 || busy !== 1'b1 || row_idx !== 4'd4)
      $display("FAIL step_busy got ovr=%0b busy=%0b idx=%0d exp 0 1 4", overrun, busy, row_idx);
    else n_pass++;
    repeat (3) cyc();
    stall_en = 1'b0;
    for (int i = 0; i < 40 && busy !== 1'b0; i++) cyc();
    repeat (4) cyc();
    n_total++;
    if (busy !== 1'b0 || commit_cnt - c0 !== 1 || gen_count !== 16'd1 || overrun !== 1'b0)
      $display("FAIL step_done got busy=%0b commits=%0d gen=%0d ovr=%0b exp 0 1 1 0",
               busy, commit_cnt - c0, gen_count, overrun);
    else n_pass++;
  endtask

  task automatic test_overrun();
    do_reset();
    run = 1'b1; stall_row = 4'd3; stall_en = 1'b1;
    c0 = commit_cnt;
    pulse_tick();
    for (int i = 0; i < 20 && row_idx !== 4'd3; i++) cyc();
    cyc(); cyc();
    pulse_tick();
    n_total++;
    if (overrun !== 1'b1 || row_idx !== 4'd3 || row_req !== 1'b1)
      $display("FAIL ovr_set got ovr=%0b idx=%0d req=%0b exp 1 3 1", overrun, row_idx, row_req);
    else n_pass++;
    stall_en = 1'b0;
    for (int i = 0; i < 40 && busy !== 1'b0; i++) cyc();
    repeat (3) cyc();
    n_total++;
    if (busy !== 1'b0 || commit_cnt - c0 !== 1 || gen_count !== 16'd1 || overrun !== 1'b1)
      $display("FAIL ovr_done got busy=%0b commits=%0d gen=%0d ovr=%0b exp 0 1 1 1",
               busy, commit_cnt - c0, gen_count, overrun);
    else n_pass++;
  endtask

  task automatic test_load_busy();
    do_reset();
    run = 1'b1;
    pulse_tick();
    for (int i = 0; i < 40 && busy !== 1'b0; i++) cyc();
    stall_row = 4'd5; stall_en = 1'b1;
    pulse_tick();
    for (int i = 0; i < 20 && row_idx !== 4'd5; i++) cyc();
    pulse_tick();
    load = 1'b1; cyc(); load = 1'b0;
    n_total++;
    if (overrun !== 1'b1 || busy !== 1'b1 || load_en !== 1'b0 || row_idx !== 4'd5)
      $display("FAIL ldb_pending got ovr=%0b busy=%0b ld=%0b idx=%0d exp 1 1 0 5", overrun, busy, load_en, row_idx);
    else n_pass++;
    stall_en = 1'b0;
    for (int i = 0; i < 40 && commit !== 1'b1; i++) cyc();
    n_total++;
    if (commit !== 1'b1) $display("FAIL ldb_commit got=%0b exp=1", commit);
    else n_pass++;
    cyc();
    n_total++;
    if (busy !== 1'b0 || load_en !== 1'b0 || gen_count !== 16'd2)
      $display("FAIL ldb_idle got busy=%0b ld=%0b gen=%0d exp 0 0 2", busy, load_en, gen_count);
    else n_pass++;
    cyc();
    n_total++;
    if (load_en !== 1'b1 || busy !== 1'b1)
      $display("FAIL ldb_load_en got ld=%0b busy=%0b exp 1 1", load_en, busy);
    else n_pass++;
    cyc();
    n_total++;
    if (load_en !== 1'b0 || busy !== 1'b0 || gen_count !== 16'd0 || overrun !== 1'b0)
      $display("FAIL ldb_after got ld=%0b busy=%0b gen=%0d ovr=%0b exp 0 0 0 0", load_en, busy, gen_count, overrun);
    else n_pass++;
  endtask

  task automatic test_load_vs_trig();
    do_reset();
    run = 1'b1;
    c0 = commit_cnt;
    load = 1'b1; tick = 1'b1; cyc(); load = 1'b0; tick = 1'b0;
    n_total++;
    if (load_en !== 1'b1 || row_req !== 1'b0)
      $display("FAIL lvt_load got ld=%0b req=%0b exp 1 0", load_en, row_req);
    else n_pass++;
    repeat (4) cyc();
    n_total++;
    if (busy !== 1'b0 || commit_cnt - c0 !== 0 || overrun !== 1'b0)
      $display("FAIL lvt_dropped got busy=%0b commits=%0d ovr=%0b exp 0 0 0", busy, commit_cnt - c0, overrun);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    run = 1'b1;
    pulse_tick();
    for (int i = 0; i < 40 && busy !== 1'b0; i++) cyc();
    stall_row = 4'd7; stall_en = 1'b1;
    pulse_tick();
    for (int i = 0; i < 20 && row_idx !== 4'd7; i++) cyc();
    n_total++;
    if (row_idx !== 4'd7 || gen_count !== 16'd1)
      $display("FAIL rst_mid_pre got idx=%0d gen=%0d exp 7 1", row_idx, gen_count);
    else n_pass++;
    c0 = commit_cnt;
    #3;
    reset = 1'b1;
    #1;
    n_total++;
    if ({row_req, commit, load_en, busy, overrun} !== 5'b0 || row_idx !== 4'd0 || gen_count !== 16'd0)
      $display("FAIL rst_mid_async got req=%0b com=%0b ld=%0b busy=%0b ovr=%0b idx=%0d gen=%0d exp all 0",
               row_req, commit, load_en, busy, overrun, row_idx, gen_count);
    else n_pass++;
    stall_en = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    n_total++;
    if (commit_cnt - c0 !== 0 || busy !== 1'b0)
      $display("FAIL rst_mid_nocommit got commits=%0d busy=%0b exp 0 0", commit_cnt - c0, busy);
    else n_pass++;
    pulse_tick();
    n_total++;
    if (row_req !== 1'b1 || row_idx !== 4'd0)
      $display("FAIL rst_mid_restart got req=%0b idx=%0d exp 1 0", row_req, row_idx);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1; tick = 0; run = 0; step = 0; load = 0; speed = 2'd0;
    done_lvl = 1'b1; stall_en = 1'b0; stall_row = 4'd0;
    test_reset();
    test_latency();
    test_speed();
    test_step();
    test_overrun();
    test_load_busy();
    test_load_vs_trig();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
